// File: rtl/mult_div_unit.sv
// Multicycle shift-add multiplier / restoring divider for MIPS mult/multu/div/divu.
// Owns HI/LO; one iteration per clock, WIDTH iterations per operation.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_count;
  logic             r_resNeg;
  logic             r_remNeg;
  logic             r_divZero;

  logic             w_startDivZero;
  logic             w_lastIter;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_trial;
  logic             w_trialOk;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prodNeg;

  assign w_startDivZero = op[1] && (b == '0);
  assign w_lastIter     = (r_count == LAST);

  // r_acc is acc_hi for mult and the partial remainder for div; r_shift is mplier/quotient.
  assign w_sum     = {1'b0, r_acc} + (r_shift[0] ? {1'b0, r_opnd} : '0);
  assign w_trial   = {r_acc, r_shift[WIDTH-1]} - {1'b0, r_opnd};
  assign w_trialOk = ~w_trial[WIDTH];
  assign w_prod    = {r_acc, r_shift};
  assign w_prodNeg = -w_prod;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_startDivZero ? DONE : PREP;
      PREP:    w_next = RUN;
      RUN:     if (w_lastIter) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= '0;
      r_acc     <= '0;
      r_shift   <= '0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_count   <= '0;
      r_resNeg  <= 1'b0;
      r_remNeg  <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op      <= op;
            r_shift   <= a;
            r_opnd    <= b;
            r_divZero <= w_startDivZero;
          end
        end
        PREP: begin
          r_acc   <= '0;
          r_count <= '0;
          if (!r_op[0]) begin
            r_shift  <= r_shift[WIDTH-1] ? -r_shift : r_shift;
            r_opnd   <= r_opnd[WIDTH-1] ? -r_opnd : r_opnd;
            r_resNeg <= r_shift[WIDTH-1] ^ r_opnd[WIDTH-1];
            r_remNeg <= r_shift[WIDTH-1];
          end else begin
            r_resNeg <= 1'b0;
            r_remNeg <= 1'b0;
          end
        end
        RUN: begin
          r_count <= r_count + 1'b1;
          if (!r_op[1]) begin
            r_acc   <= w_sum[WIDTH:1];
            r_shift <= {w_sum[0], r_shift[WIDTH-1:1]};
          end else if (w_trialOk) begin
            r_acc   <= w_trial[WIDTH-1:0];
            r_shift <= {r_shift[WIDTH-2:0], 1'b1};
          end else begin
            r_acc   <= {r_acc[WIDTH-2:0], r_shift[WIDTH-1]};
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          // Sign fix-up of the magnitude result happens as HI/LO are loaded.
          if (r_op[1]) begin
            r_lo <= r_resNeg ? -r_shift : r_shift;
            r_hi <= r_remNeg ? -r_acc : r_acc;
          end else if (r_resNeg) begin
            r_hi <= w_prodNeg[2*WIDTH-1:WIDTH];
            r_lo <= w_prodNeg[WIDTH-1:0];
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign div_zero = r_divZero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized operations
// compared against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [31:0] expHi = '0;
  logic [31:0] expLo = '0;
  logic        expDz = 1'b0;
  int          expLat = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural operands.
  task automatic modelOp(input logic [1:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(aIn));
    sb = longint'($signed(bIn));
    expLat = 35;
    case (opIn)
      2'b00: begin
        p = 64'(sa * sb);
        expHi = p[63:32]; expLo = p[31:0]; expDz = 1'b0;
      end
      2'b01: begin
        p = {32'b0, aIn} * {32'b0, bIn};
        expHi = p[63:32]; expLo = p[31:0]; expDz = 1'b0;
      end
      default: begin
        if (bIn == 32'd0) begin
          expDz = 1'b1;
          expLat = 1;
        end else begin
          expDz = 1'b0;
          if (opIn == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
            expLo = q[31:0];
            expHi = r[31:0];
          end else begin
            expLo = aIn / bIn;
            expHi = aIn % bIn;
          end
        end
      end
    endcase
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".hi"}, {32'b0, hi}, {32'b0, expHi});
    checkValue({tag, ".lo"}, {32'b0, lo}, {32'b0, expLo});
    checkValue({tag, ".div_zero"}, {63'b0, div_zero}, {63'b0, expDz});
  endtask

  // Issues one operation, scrambles inputs (including stray starts) while busy,
  // and waits a bounded number of cycles for done.
  task automatic applyStimulus(input string tag, input logic [1:0] opIn,
                               input logic [31:0] aIn, input logic [31:0] bIn, input bit noise);
    int cyc;
    bit seen;
    logic [31:0] prevHi, prevLo;
    prevHi = expHi;
    prevLo = expLo;
    @(negedge clk);
    start = 1'b1; op = opIn; a = aIn; b = bIn;
    modelOp(opIn, aIn, bIn);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc <= 60) begin
      checkValue({tag, ".busy"}, {63'b0, busy}, 64'd1);
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
      end else begin
        checkValue({tag, ".hold_hi"}, {32'b0, hi}, {32'b0, prevHi});
        checkValue({tag, ".hold_lo"}, {32'b0, lo}, {32'b0, prevLo});
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = (($urandom & 1) == 0) ? 32'd0 : $urandom;
        @(negedge clk);
        cyc++;
      end
    end
    checkValue({tag, ".latency"}, seen ? 64'(cyc) : 64'd0, 64'(expLat));
    checkOutput(tag);
    @(negedge clk);
    checkValue({tag, ".idle_busy"}, {63'b0, busy}, 64'd0);
    checkValue({tag, ".idle_done"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checkValue("reset.busy", {63'b0, busy}, 64'd0);
    checkValue("reset.done", {63'b0, done}, 64'd0);
    checkOutput("reset");
    reset = 1'b0;

    applyStimulus("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    checkValue("multu_max.lit_hi", {32'b0, hi}, 64'hFFFFFFFE);
    applyStimulus("mult_neg3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 1'b1);
    checkValue("mult_neg3x5.lit_lo", {32'b0, lo}, 64'hFFFFFFF1);
    applyStimulus("mult_5xneg3", 2'b00, 32'd5, 32'hFFFFFFFD, 1'b1);
    applyStimulus("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 1'b1);
    checkValue("div_neg7_2.lit_hi", {32'b0, hi}, 64'hFFFFFFFF);
    applyStimulus("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b1);
    applyStimulus("divu_by0", 2'b11, 32'd100, 32'd0, 1'b0);
    checkValue("divu_by0.lit_lo", {32'b0, lo}, 64'd14);
    applyStimulus("mult_clr_dz", 2'b00, 32'd7, 32'd6, 1'b0);
    applyStimulus("div_by0_signed", 2'b10, 32'h12345678, 32'd0, 1'b0);
    applyStimulus("div_minint_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    checkValue("div_minint_m1.lit_lo", {32'b0, lo}, 64'h80000000);
    applyStimulus("div_pos_neg", 2'b10, 32'd7, 32'hFFFFFFFE, 1'b1);
    applyStimulus("divu_small", 2'b11, 32'd3, 32'hFFFFFFFF, 1'b1);

    // Stray start mid-operation is dropped; reset then aborts the operation.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = (c == 5);
      op = (c == 5) ? 2'b10 : 2'b01;
      b = (c == 5) ? 32'd0 : 32'd4;
      if (c == 6) checkValue("ignored_start.done", {63'b0, done}, 64'd0);
      if (c == 10) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    expHi = '0; expLo = '0; expDz = 1'b0;
    checkValue("abort.busy", {63'b0, busy}, 64'd0);
    checkValue("abort.done", {63'b0, done}, 64'd0);
    checkOutput("abort");
    repeat (40) begin
      @(negedge clk);
      checkValue("abort.no_done", {63'b0, done}, 64'd0);
    end
    applyStimulus("multu_3x4", 2'b01, 32'd3, 32'd4, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  rOp;
      logic [31:0] rA, rB;
      rOp = 2'($urandom);
      rA = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0:       rB = 32'd0;
        1:       rB = 32'd1;
        2:       rB = 32'hFFFFFFFF;
        3:       rB = 32'($urandom_range(2, 50));
        default: rB = $urandom;
      endcase
      applyStimulus($sformatf("rand%0d", i), rOp, rA, rB, 1'b1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
